// File: rtl/rng_sched_pkg.sv
// Shared types and constants for the RNG byte scheduler: the dispatch FSM states
// and the drop counter width.
package rng_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GUARD = 1'b1
  } sched_state_e;

  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/rng_byte_fifo.sv
// Byte FIFO with occupancy output. Head data is readable combinationally; a push
// while full and a pop while empty are ignored.
module rng_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level already mark
  // every entry invalid, and a reset here would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rng_tx_scheduler.sv
// Packs de-biased random bits into bytes, buffers them and dispatches them to a
// bank of UART transmitters with rotating priority. Define RNG_SCHED_HEALTH_EN
// to enable the repetition health test.
module rng_tx_scheduler
  import rng_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned REP_LIMIT  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  input  logic [NUM_PORTS-1:0]        tx_ready,
  output logic [NUM_PORTS-1:0]        tx_start,
  output logic [7:0]                  tx_byte,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [DROP_CNT_W-1:0]       drop_count,
  output logic                        health_fail
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 1 || NUM_PORTS > 16 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REP_LIMIT < 1) begin : g_bad_params
    $error("rng_tx_scheduler: illegal parameter set");
  end

  // ---------------- bit packer ----------------
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [6:0] shreg_q, shreg_d;
  logic       byte_done;
  logic [7:0] new_byte;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    new_byte  = {bit_in, shreg_q};
    if (bit_valid) begin
      if (bit_idx_q == 3'd7) begin
        byte_done = 1'b1;
        bit_idx_d = 3'd0;
      end else begin
        shreg_d[bit_idx_q] = bit_in;
        bit_idx_d          = bit_idx_q + 3'd1;
      end
    end
  end

  // ---------------- health test ----------------
  logic health_block;

`ifdef RNG_SCHED_HEALTH_EN
  localparam int unsigned RUN_W = $clog2(REP_LIMIT + 1);

  logic [7:0]       prev_byte_q;
  logic             prev_vld_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             fail_q, fail_d;

  // The run length counts the current byte, so REP_LIMIT identical bytes trip it.
  always_comb begin
    run_d  = run_q;
    fail_d = fail_q;
    if (byte_done) begin
      if (prev_vld_q && (new_byte == prev_byte_q))
        run_d = (run_q == RUN_W'(REP_LIMIT)) ? run_q : run_q + RUN_W'(1);
      else
        run_d = RUN_W'(1);
      if (run_d == RUN_W'(REP_LIMIT)) fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_byte_q <= '0;
      prev_vld_q  <= 1'b0;
      run_q       <= '0;
      fail_q      <= 1'b0;
    end else begin
      if (byte_done) begin
        prev_byte_q <= new_byte;
        prev_vld_q  <= 1'b1;
      end
      run_q  <= run_d;
      fail_q <= fail_d;
    end
  end

  assign health_block = fail_q;
  assign health_fail  = fail_q;
`else
  assign health_block = 1'b0;
  assign health_fail  = 1'b0;
`endif

  // ---------------- FIFO and drop counter ----------------
  logic                  push_req, fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [7:0]            fifo_head;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign push_req  = byte_done && !health_block;
  assign fifo_push = push_req && !fifo_full;
  assign drop      = push_req && fifo_full;

  rng_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .push_data_i (new_byte),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  // ---------------- dispatch FSM ----------------
  sched_state_e         state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] tx_start_q, tx_start_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 hit;
  logic [PW-1:0]        hit_idx, cand_idx;
  int unsigned          cand;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tx_start_d = '0;
    tx_byte_d  = tx_byte_q;
    fifo_pop   = 1'b0;
    hit        = 1'b0;
    hit_idx    = '0;
    cand       = 0;
    cand_idx   = '0;

    // First ready port at or above rr_ptr, wrapping modulo NUM_PORTS.
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = PW'(cand);
      if (!hit && tx_ready[cand_idx]) begin
        hit     = 1'b1;
        hit_idx = cand_idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && hit) begin
          tx_start_d[hit_idx] = 1'b1;
          tx_byte_d           = fifo_head;
          fifo_pop            = 1'b1;
          rr_ptr_d            = (hit_idx == PW'(NUM_PORTS - 1)) ? '0 : hit_idx + PW'(1);
          state_d             = GUARD;
        end
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rr_ptr_q   <= '0;
      tx_start_q <= '0;
      tx_byte_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_rng_tx_scheduler.sv
// Self-checking bench for rng_tx_scheduler: a scoreboard of expected (port, byte)
// starts is filled as bytes are fed and drained by a monitor on the falling edge.
module tb_rng_tx_scheduler;

  localparam int NUM_PORTS  = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int REP_LIMIT  = 4;

  logic                        clk;
  logic                        rst_n;
  logic                        bit_in;
  logic                        bit_valid;
  logic [NUM_PORTS-1:0]        tx_ready;
  logic [NUM_PORTS-1:0]        tx_start;
  logic [7:0]                  tx_byte;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [15:0]                 drop_count;
  logic                        health_fail;

  typedef struct packed {
    logic [NUM_PORTS-1:0] start;
    logic [7:0]           data;
  } exp_t;

  exp_t                 exp_q[$];
  int                   n_tests = 0;
  int                   n_fail  = 0;
  int                   cyc     = 0;
  logic [NUM_PORTS-1:0] prev_start = '0;

  rng_tx_scheduler #(
    .NUM_PORTS  (NUM_PORTS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .REP_LIMIT  (REP_LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every start pulse must match the oldest expectation and
  // must not follow another start on the previous cycle.
  always @(negedge clk) begin
    exp_t e;
    if (tx_start !== '0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL start_unexpected: tx_start=%b tx_byte=%h, required no start", tx_start, tx_byte);
      end else begin
        e = exp_q.pop_front();
        if (tx_start !== e.start || tx_byte !== e.data) begin
          n_fail++;
          $display("FAIL start_match: tx_start=%b tx_byte=%h, required tx_start=%b tx_byte=%h",
                   tx_start, tx_byte, e.start, e.data);
        end
      end
      n_tests++;
      if (prev_start !== '0) begin
        n_fail++;
        $display("FAIL guard_gap: start %b directly after start %b, required an idle cycle",
                 tx_start, prev_start);
      end
    end
    prev_start = tx_start;
  end

  task automatic expect_start(input int port, input logic [7:0] data);
    exp_t e;
    e.start = '0;
    e.start[port] = 1'b1;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [NUM_PORTS-1:0] ready);
    @(negedge clk);
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tx_ready  = ready;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives 8 valid bits LSB-first on consecutive cycles; bit_valid stays high.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bit_in    = b[i];
      bit_valid = 1'b1;
    end
  endtask

  task automatic idle_bits();
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_level == 0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: %0d starts pending, fifo_level=%0d, required 0 and 0",
               name, exp_q.size(), fifo_level);
    end
  endtask

  task automatic test_reset();
    do_reset('1);
    n_tests += 5;
    if (tx_start !== '0)    begin n_fail++; $display("FAIL reset_tx_start: %b, required 0", tx_start); end
    if (tx_byte !== 8'h00)  begin n_fail++; $display("FAIL reset_tx_byte: %h, required 00", tx_byte); end
    if (fifo_level !== 0)   begin n_fail++; $display("FAIL reset_level: %0d, required 0", fifo_level); end
    if (drop_count !== 0)   begin n_fail++; $display("FAIL reset_drop: %0d, required 0", drop_count); end
    if (health_fail !== 0)  begin n_fail++; $display("FAIL reset_health: %b, required 0", health_fail); end
  endtask

  task automatic test_single_byte();
    do_reset('1);
    expect_start(0, 8'h05);
    send_byte(8'h05);
    idle_bits();
    n_tests += 2;
    if (tx_start !== '0) begin n_fail++; $display("FAIL single_early: tx_start=%b, required 0", tx_start); end
    if (fifo_level !== 1) begin n_fail++; $display("FAIL single_level: %0d, required 1", fifo_level); end
    @(negedge clk);
    n_tests += 3;
    if (tx_start !== 4'b0001) begin n_fail++; $display("FAIL single_start: %b, required 0001", tx_start); end
    if (tx_byte !== 8'h05)    begin n_fail++; $display("FAIL single_byte: %h, required 05", tx_byte); end
    if (fifo_level !== 0)     begin n_fail++; $display("FAIL single_pop: %0d, required 0", fifo_level); end
    // rr_ptr is now 1: the next byte must go to port 1.
    expect_start(1, 8'h9C);
    send_byte(8'h9C);
    idle_bits();
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    int  last_c = 0;
    bit  got;
    do_reset('0);
    for (int k = 0; k < 5; k++) begin
      expect_start(k % NUM_PORTS, 8'h11 + 8'(k));
      send_byte(8'h11 + 8'(k));
    end
    idle_bits();
    n_tests++;
    if (fifo_level !== 5) begin n_fail++; $display("FAIL rr_level: %0d, required 5", fifo_level); end
    tx_ready = '1;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (tx_start !== '0) got = 1'b1;
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL rr_timeout: start %0d not seen, required within 10 cycles", k);
      end else if (k > 0 && (cyc - last_c) != 2) begin
        n_fail++;
        $display("FAIL rr_spacing: start %0d after %0d cycles, required 2", k, cyc - last_c);
      end
      last_c = cyc;
    end
    wait_drain("rr");
  endtask

  task automatic test_skip_busy();
    do_reset('1);
    expect_start(0, 8'hA1);
    send_byte(8'hA1);
    idle_bits();
    expect_start(1, 8'hA2);
    send_byte(8'hA2);
    idle_bits();
    wait_drain("skip_pre");
    tx_ready = 4'b1011;
    expect_start(3, 8'hB1);
    expect_start(0, 8'hB2);
    expect_start(1, 8'hB3);
    expect_start(3, 8'hB4);
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    send_byte(8'hB4);
    idle_bits();
    wait_drain("skip");
  endtask

  task automatic test_overflow();
    do_reset('0);
    for (int k = 0; k < 8; k++) begin
      expect_start(k % NUM_PORTS, 8'h40 + 8'(k));
      send_byte(8'h40 + 8'(k));
    end
    idle_bits();
    n_tests += 2;
    if (fifo_level !== 8) begin n_fail++; $display("FAIL ovf_full_level: %0d, required 8", fifo_level); end
    if (drop_count !== 0) begin n_fail++; $display("FAIL ovf_full_drop: %0d, required 0", drop_count); end
    send_byte(8'hE0);
    send_byte(8'hE1);
    idle_bits();
    n_tests += 2;
    if (fifo_level !== 8) begin n_fail++; $display("FAIL ovf_level: %0d, required 8", fifo_level); end
    if (drop_count !== 2) begin n_fail++; $display("FAIL ovf_drop: %0d, required 2", drop_count); end
    tx_ready = '1;
    wait_drain("ovf");
    n_tests++;
    if (drop_count !== 2) begin n_fail++; $display("FAIL ovf_drop_hold: %0d, required 2", drop_count); end
  endtask

  task automatic test_reset_mid();
    do_reset('0);
    expect_start(0, 8'h5A);
    send_byte(8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_in    = 1'b1;
      bit_valid = 1'b1;
    end
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tx_ready  = '1;
    @(negedge clk);
    n_tests++;
    if (tx_start !== 4'b0001) begin n_fail++; $display("FAIL mid_issue: tx_start=%b, required 0001", tx_start); end
    #1 rst_n = 1'b0;
    #1;
    n_tests += 4;
    if (tx_start !== '0)   begin n_fail++; $display("FAIL mid_tx_start: %b, required 0", tx_start); end
    if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL mid_tx_byte: %h, required 00", tx_byte); end
    if (fifo_level !== 0)  begin n_fail++; $display("FAIL mid_level: %0d, required 0", fifo_level); end
    if (drop_count !== 0)  begin n_fail++; $display("FAIL mid_drop: %0d, required 0", drop_count); end
    @(negedge clk);
    rst_n = 1'b1;
    expect_start(0, 8'h3C);
    send_byte(8'h3C);
    idle_bits();
    wait_drain("mid");
  endtask

`ifdef RNG_SCHED_HEALTH_EN
  task automatic test_health();
    do_reset('0);
    for (int k = 0; k < 3; k++) begin
      expect_start(k, 8'hAA);
      send_byte(8'hAA);
    end
    idle_bits();
    n_tests++;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL health_early: %b, required 0", health_fail); end
    expect_start(3, 8'hAA);
    send_byte(8'hAA);
    idle_bits();
    n_tests += 2;
    if (health_fail !== 1'b1) begin n_fail++; $display("FAIL health_trip: %b, required 1", health_fail); end
    if (fifo_level !== 4)     begin n_fail++; $display("FAIL health_level: %0d, required 4", fifo_level); end
    send_byte(8'h12);
    send_byte(8'h34);
    idle_bits();
    n_tests += 2;
    if (fifo_level !== 4) begin n_fail++; $display("FAIL health_block: level %0d, required 4", fifo_level); end
    if (drop_count !== 0) begin n_fail++; $display("FAIL health_drop: %0d, required 0", drop_count); end
    tx_ready = '1;
    wait_drain("health");
    n_tests++;
    if (health_fail !== 1'b1) begin n_fail++; $display("FAIL health_sticky: %b, required 1", health_fail); end
  endtask
`else
  task automatic test_health();
    do_reset('1);
    for (int k = 0; k < 5; k++) begin
      expect_start(k % NUM_PORTS, 8'hAA);
      send_byte(8'hAA);
    end
    idle_bits();
    wait_drain("health_off");
    n_tests += 2;
    if (health_fail !== 1'b0) begin n_fail++; $display("FAIL health_off: %b, required 0", health_fail); end
    if (drop_count !== 0)     begin n_fail++; $display("FAIL health_off_drop: %0d, required 0", drop_count); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    tx_ready  = '0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_skip_busy();
    test_overflow();
    test_reset_mid();
    test_health();
    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected starts never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_tx_scheduler.md
# rng_tx_scheduler

Collects de-biased random bits into bytes, buffers them in a small FIFO, and shares the byte stream between NUM_PORTS UART transmitters with rotating priority that skips busy ports. It sits between the Von Neumann de-bias stage of the hardware RNG core and the bank of `uart_transmitter` instances. It replaces ad-hoc in-order port stepping with buffered, fair, throughput-preserving dispatch.

## Interface
- `NUM_PORTS`, 4: number of UART transmitters served (1..16).
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥2.
- `REP_LIMIT`, 4: consecutive identical bytes that trip the health test; used only with the macro.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `bit_in` in 1: de-biased random bit.
- `bit_valid` in 1: `bit_in` valid this cycle.
- `tx_ready` in NUM_PORTS: per-port UART idle flag.
- `tx_start` out NUM_PORTS: one-hot, single-cycle start pulse per port.
- `tx_byte` out 8: byte for the started port; registered.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `drop_count` out 16: bytes discarded on full FIFO; saturating.
- `health_fail` out 1: sticky repetition-test failure.

## Operation
- **Packer:**
  - 3-bit index plus 7-bit shift register; bits are packed LSB-first.
  - The first valid bit after reset is bit 0.
  - On the 8th valid bit, the byte `{bit_in, shreg[6:0]}` is pushed and the index wraps to 0.
  - No bits are wasted between bytes.
- **Push rule:**
  - The push is accepted if the FIFO is not full, evaluated before any same-cycle pop.
  - If the FIFO is full, the byte is dropped and `drop_count` increments, saturating at 0xFFFF.
  - A simultaneous push and pop with the FIFO not full leaves the level unchanged.
- **Scheduler FSM:** two states, `IDLE` and `GUARD`.
  - In `IDLE`, when the FIFO is non-empty, the scheduler searches `tx_ready` from `rr_ptr` upward, modulo NUM_PORTS.
    - On a hit at port p: set `tx_start[p]`=1, load `tx_byte` from the FIFO head, pop, set `rr_ptr` to (p+1) mod NUM_PORTS, and go to `GUARD`.
    - With no ready port, or an empty FIFO, stay in `IDLE`; `rr_ptr` is unchanged.
  - `GUARD` lasts one cycle. It drops `tx_start` and issues nothing, covering the one-cycle UART `tx_ready` deassert latency. It then returns to `IDLE`.
- `tx_byte` holds its value until the next issue. The UART copies the byte on start.
- At most one `tx_start` bit is high in any cycle.
- **Reset:** asynchronous and applies mid-operation with no handshake.
  - `tx_start`=0, `tx_byte`=0, `fifo_level`=0, `drop_count`=0, `health_fail`=0.
  - FSM=`IDLE`, `rr_ptr`=0, packer index=0.
  - A partial byte is discarded.

## Timing
- The 8th bit is sampled at edge E0; the FIFO is non-empty after E0. If a port is ready, `tx_start` is high from E1 to E2.
- Latency from the last bit to the start pulse is 1 cycle, with an empty FIFO and an idle scheduler.
- Peak dispatch rate is 1 byte per 2 cycles.
- `fifo_level` and `drop_count` update on the edge of the push or drop.

## Configuration
- `RNG_SCHED_HEALTH_EN` defined:
  - Each completed byte is compared with the previous completed byte, whether pushed or dropped.
  - A run counter counts identical bytes; on reaching `REP_LIMIT`, `health_fail` sets and stays set until reset.
  - While `health_fail` is set, pushes are suppressed: no FIFO write and no `drop_count` increment. Bytes already in the FIFO still drain.
- Undefined: no compare or run logic; `health_fail` is tied to 0.

## Structure
- Package `rng_sched_pkg`: FSM state enum (`IDLE`, `GUARD`) and the `DROP_CNT_W`=16 constant.
- Sub-module `rng_byte_fifo`, parameterised by depth:
  - push/pop, `full`/`empty`, level output.
  - Head data readable combinationally.
- Priority search stays in the top module as a loop.

## Test plan
- **Single byte:** reset, then feed bits 1,0,1,0,0,0,0,0 with all ports ready → `tx_byte`=0x05 and `tx_start`=4'b0001 one cycle after the 8th bit; `rr_ptr`=1.
- **Round-robin:** queue 5 bytes 0x11..0x15 with all ports ready → starts on ports 0,1,2,3,0 in order, each followed by a `GUARD` gap.
- **Skip busy:** `tx_ready`=4'b1011, `rr_ptr`=2 → port 3 starts, then port 0 for the next byte; port 2 is never started.
- **Overflow:** all `tx_ready`=0; push 10 bytes with FIFO_DEPTH=8 → `fifo_level`=8, `drop_count`=2.
- **Reset mid-operation:** assert `reset` low during `GUARD` after 3 bits of a byte → all outputs 0; the next byte after release packs from bit 0.
- **Health (macro on), REP_LIMIT=4:** feed 0xAA four times → `health_fail`=1 after the 4th byte; further distinct bytes are not pushed; `fifo_level` drains to 0.
